wb_stage: RTL

//  Write-back stage directly upstream of the integer register file. Accepts results from
//  EXU (ALU/CSR) and LSU (loads) over valid/ready, arbitrates between them, aligns and

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_load_align.sv | 47 ++++
 rtl/wb_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load funct3 encodings, the
// internal result record carried from the arbiter to the output register,
// and sign/zero extension helpers used by the load aligner.
package wb_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Load funct3 encodings. 3, 6 and 7 are not loads; the aligner passes the
  // raw word through for them rather than flagging an error.
  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  // One result selected by the arbiter, before the rd==0 write suppression.
  typedef struct packed {
    logic                 wen;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [WB_DATA_W-1:0] ext_byte(input logic [7:0] b,
                                                    input logic       sgn);
    return {{(WB_DATA_W-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [WB_DATA_W-1:0] ext_half(input logic [15:0] h,
                                                    input logic        sgn);
    return {{(WB_DATA_W-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Purpose : extracts and extends the addressed byte/halfword from a load word.
// Latency : purely combinational, zero cycles.
// Backpr. : none; no handshake, output follows inputs.
// Ports   : i_rdata   raw aligned word from the LSU
//           i_addr_lo byte offset of the load address
//           i_funct3  load type
//           o_data    aligned, extended result
module wb_load_align
  import wb_pkg::*;
(
  input  logic [WB_DATA_W-1:0] i_rdata,
  input  logic [1:0]           i_addr_lo,
  input  logic [2:0]           i_funct3,
  output logic [WB_DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Halfword loads ignore addr_lo[0]; a misaligned half still returns the
  // containing aligned half, misalignment is trapped upstream.
  always_comb begin
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      LOAD_LB:  o_data = ext_byte(w_byte, 1'b1);
      LOAD_LBU: o_data = ext_byte(w_byte, 1'b0);
      LOAD_LH:  o_data = ext_half(w_half, 1'b1);
      LOAD_LHU: o_data = ext_half(w_half, 1'b0);
      default:  o_data = i_rdata;  // LW and the non-load encodings
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Purpose : write-back stage; arbitrates EXU/LSU results, aligns loads,
//           registers the result and drives the register-file write port.
// Latency : accept at edge N -> rf_wen/retire high in cycle N+1.
// Backpr. : lsu_ready always 1; exu_ready = ~lsu_valid (LSU has priority).
// Optional: WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
// Ports   : clk, rst (sync, active-high)
//           exu_valid/exu_ready/exu_wen/exu_rd/exu_data    EXU result channel
//           lsu_valid/lsu_ready/lsu_rd/lsu_rdata/
//           lsu_addr_lo/lsu_funct3                          LSU load channel
//           rf_wen/rf_waddr/rf_wdata                        RF write port
//           fwd_valid/fwd_rd/fwd_data                       (WB_FWD_EN only)
//           retire                                          one-cycle commit pulse
module wb_stage
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,  // must match the register file
  parameter int DATA_WIDTH = WB_DATA_W   // load aligner supports 32 only
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,

  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [1:0]            lsu_addr_lo,
  input  logic [2:0]            lsu_funct3,

  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef WB_FWD_EN
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic                  retire
);

  logic [DATA_WIDTH-1:0] w_load_data;
  wb_req_t               w_exu_req;
  wb_req_t               w_lsu_req;
  wb_req_t               w_sel_req;
  logic                  w_accept;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_retire;

  wb_load_align u_load_align (
    .i_rdata   (lsu_rdata),
    .i_addr_lo (lsu_addr_lo),
    .i_funct3  (lsu_funct3),
    .o_data    (w_load_data)
  );

  // The RF never back-pressures and the output register refills every
  // cycle, so the stage itself never stalls; only EXU can be held off.
  assign lsu_ready = 1'b1;
  assign exu_ready = ~lsu_valid;

  // Loads always write their destination.
  always_comb begin
    w_lsu_req      = '0;
    w_lsu_req.wen  = 1'b1;
    w_lsu_req.rd   = lsu_rd;
    w_lsu_req.data = w_load_data;
  end

  always_comb begin
    w_exu_req      = '0;
    w_exu_req.wen  = exu_wen;
    w_exu_req.rd   = exu_rd;
    w_exu_req.data = exu_data;
  end

  // Fixed priority: LSU wins. At most one result is accepted per cycle.
  always_comb begin
    w_sel_req = w_exu_req;
    w_accept  = 1'b0;
    if (lsu_valid) begin
      w_sel_req = w_lsu_req;
      w_accept  = 1'b1;
    end else if (exu_valid) begin
      w_sel_req = w_exu_req;
      w_accept  = 1'b1;
    end
  end

  // Writes to x0 are dropped here but the instruction still retires.
  // Address/data hold through idle cycles so the RF port stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_retire <= 1'b0;
    end else if (w_accept) begin
      r_wen    <= w_sel_req.wen & (w_sel_req.rd != '0);
      r_waddr  <= w_sel_req.rd;
      r_wdata  <= w_sel_req.data;
      r_retire <= 1'b1;
    end else begin
      r_wen    <= 1'b0;
      r_retire <= 1'b0;
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign retire   = r_retire;

`ifdef WB_FWD_EN
  // Bypass tap: the value the RF is about to capture this cycle.
  assign fwd_valid = r_wen;
  assign fwd_rd    = r_waddr;
  assign fwd_data  = r_wdata;
`endif

endmodule
